// File: rtl/flght_seq_if.sv
// Inertial/command inputs and ESC speed outputs of the flight sequencer.
// Combinational bundle only: no storage, no latency.
// No backpressure: drops while busy are counted inside the sequencer.
interface flght_seq_if;
    logic               vld;
    logic               inertial_cal;
    logic signed [15:0] d_ptch;
    logic signed [15:0] d_roll;
    logic signed [15:0] d_yaw;
    logic signed [15:0] ptch;
    logic signed [15:0] roll;
    logic signed [15:0] yaw;
    logic        [8:0]  thrst;
    logic               busy;
    logic               spd_vld;
    logic        [10:0] frnt_spd;
    logic        [10:0] bck_spd;
    logic        [10:0] lft_spd;
    logic        [10:0] rght_spd;
    logic        [7:0]  ovr_cnt;

    // Source side: the inertial front end / command config
    modport master (
        output vld, inertial_cal, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
        input  busy, spd_vld, frnt_spd, bck_spd, lft_spd, rght_spd, ovr_cnt
    );

    // Sequencer side
    modport slave (
        input  vld, inertial_cal, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
        output busy, spd_vld, frnt_spd, bck_spd, lft_spd, rght_spd, ovr_cnt
    );
endinterface

// File: rtl/flght_seq.sv
// Shared P/D datapath stepped over pitch/roll/yaw, then mixed into four motor speeds.
// Latency: accept at t, speeds and spd_vld visible at t+5; one reading per 5 cycles.
// No stall: vld seen while busy is dropped and counted in a saturating ovr_cnt.
module flght_seq #(
    parameter int          D_DEPTH       = 14,
    parameter int          D_COEFF       = 7,
    parameter logic [10:0] CAL_SPEED     = 11'h1B0,
    parameter logic [12:0] MIN_RUN_SPEED = 13'h200
) (
    input  logic         clk,
    input  logic         rst_n,
    flght_seq_if.slave   bus
);

    localparam int PW = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
    localparam logic [PW-1:0]      WPTR_LAST = PW'(D_DEPTH - 1);
    localparam logic signed [11:0] COEF      = 12'(D_COEFF);
    localparam logic signed [16:0] ERR_HI    = 17'sd511;
    localparam logic signed [16:0] ERR_LO    = -17'sd512;
    localparam logic signed [9:0]  DD_HI     = 10'sd31;
    localparam logic signed [9:0]  DD_LO     = -10'sd32;

    typedef enum logic [2:0] {IDLE, PTCH, ROLL, YAW, MIX} state_t;

    state_t             state;
    logic               busy_r;
    logic               spd_vld_r;
    logic        [10:0] frnt_r, bck_r, lft_r, rght_r;
    logic        [7:0]  ovr_r;
    logic        [PW-1:0] wptr;

    // Captured reading
    logic signed [15:0] dp_q, dr_q, dy_q, ap_q, ar_q, ay_q;
    logic        [8:0]  thr_q;

    // Per-axis error history for the derivative term
    logic signed [9:0]  q_ptch [D_DEPTH];
    logic signed [9:0]  q_roll [D_DEPTH];
    logic signed [9:0]  q_yaw  [D_DEPTH];

    // Per-axis P/D results
    logic signed [9:0]  pt_p, pt_r, pt_y;
    logic signed [11:0] dt_p, dt_r, dt_y;

    // Shared datapath signals
    logic signed [15:0] act, des;
    logic signed [9:0]  old;
    logic signed [16:0] err;
    logic signed [9:0]  err_sat;
    logic signed [9:0]  pterm;
    logic signed [9:0]  d_diff;
    logic signed [5:0]  d_sat;
    logic signed [11:0] dterm;

    // Mixer signals
    logic signed [12:0] s_base, t_p, t_r, t_y;
    logic signed [12:0] frnt_sum, bck_sum, lft_sum, rght_sum;

    function automatic logic [10:0] sat11(input logic signed [12:0] v);
        if (v < 13'sd0)
            return 11'd0;
        else if (v > 13'sd2047)
            return 11'h7FF;
        else
            return v[10:0];
    endfunction

    // Shared axis step: pick the axis for this state, then error/saturate/P/D
    always_comb begin
        act = '0;
        des = '0;
        old = '0;
        case (state)
            PTCH: begin act = ap_q; des = dp_q; old = q_ptch[wptr]; end
            ROLL: begin act = ar_q; des = dr_q; old = q_roll[wptr]; end
            YAW:  begin act = ay_q; des = dy_q; old = q_yaw[wptr];  end
            default: ;
        endcase

        err = {act[15], act} - {des[15], des};
        if (err > ERR_HI)
            err_sat = 10'sd511;
        else if (err < ERR_LO)
            err_sat = -10'sd512;
        else
            err_sat = err[9:0];

        pterm  = (err_sat >>> 1) + (err_sat >>> 3);
        d_diff = err_sat - old;

        if (d_diff > DD_HI)
            d_sat = 6'sd31;
        else if (d_diff < DD_LO)
            d_sat = -6'sd32;
        else
            d_sat = d_diff[5:0];

        dterm = $signed({{6{d_sat[5]}}, d_sat}) * COEF;
    end

    // Motor mix of the three axis results around the thrust-based operating point
    always_comb begin
        s_base   = $signed(MIN_RUN_SPEED + {4'b0, thr_q});
        t_p      = $signed({{3{pt_p[9]}}, pt_p}) + $signed({dt_p[11], dt_p});
        t_r      = $signed({{3{pt_r[9]}}, pt_r}) + $signed({dt_r[11], dt_r});
        t_y      = $signed({{3{pt_y[9]}}, pt_y}) + $signed({dt_y[11], dt_y});
        frnt_sum = s_base - t_p - t_y;
        bck_sum  = s_base + t_p - t_y;
        lft_sum  = s_base - t_r + t_y;
        rght_sum = s_base + t_r + t_y;
    end

    // Sequencer FSM with registered outputs, history queues and drop counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            spd_vld_r <= 1'b0;
            frnt_r    <= '0;
            bck_r     <= '0;
            lft_r     <= '0;
            rght_r    <= '0;
            ovr_r     <= '0;
            wptr      <= '0;
            dp_q      <= '0;
            dr_q      <= '0;
            dy_q      <= '0;
            ap_q      <= '0;
            ar_q      <= '0;
            ay_q      <= '0;
            thr_q     <= '0;
            pt_p      <= '0;
            pt_r      <= '0;
            pt_y      <= '0;
            dt_p      <= '0;
            dt_r      <= '0;
            dt_y      <= '0;
            for (int i = 0; i < D_DEPTH; i++) begin
                q_ptch[i] <= '0;
                q_roll[i] <= '0;
                q_yaw[i]  <= '0;
            end
        end else begin
            spd_vld_r <= 1'b0;

            if (state != IDLE && bus.vld && ovr_r != 8'hFF)
                ovr_r <= ovr_r + 8'd1;

            case (state)
                IDLE: begin
                    if (bus.vld) begin
                        dp_q   <= bus.d_ptch;
                        dr_q   <= bus.d_roll;
                        dy_q   <= bus.d_yaw;
                        ap_q   <= bus.ptch;
                        ar_q   <= bus.roll;
                        ay_q   <= bus.yaw;
                        thr_q  <= bus.thrst;
                        busy_r <= 1'b1;
                        state  <= PTCH;
                    end
                end
                PTCH: begin
                    q_ptch[wptr] <= err_sat;
                    pt_p         <= pterm;
                    dt_p         <= dterm;
                    state        <= ROLL;
                end
                ROLL: begin
                    q_roll[wptr] <= err_sat;
                    pt_r         <= pterm;
                    dt_r         <= dterm;
                    state        <= YAW;
                end
                YAW: begin
                    q_yaw[wptr] <= err_sat;
                    pt_y        <= pterm;
                    dt_y        <= dterm;
                    wptr        <= (wptr == WPTR_LAST) ? '0 : wptr + 1'b1;
                    state       <= MIX;
                end
                MIX: begin
                    frnt_r    <= sat11(frnt_sum);
                    bck_r     <= sat11(bck_sum);
                    lft_r     <= sat11(lft_sum);
                    rght_r    <= sat11(rght_sum);
                    spd_vld_r <= 1'b1;
                    busy_r    <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase

            // Calibration overrides any mixed result, including the MIX cycle
            if (bus.inertial_cal) begin
                frnt_r <= CAL_SPEED;
                bck_r  <= CAL_SPEED;
                lft_r  <= CAL_SPEED;
                rght_r <= CAL_SPEED;
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.spd_vld  = spd_vld_r;
    assign bus.frnt_spd = frnt_r;
    assign bus.bck_spd  = bck_r;
    assign bus.lft_spd  = lft_r;
    assign bus.rght_spd = rght_r;
    assign bus.ovr_cnt  = ovr_r;

endmodule

// File: tb/tb_flght_seq.sv
// Directed and randomized checks of flght_seq against a transaction-level reference.
// Latency: expects speeds/spd_vld five cycles after each accept.
// Drives vld noise while busy and expects each such cycle to be counted as a drop.
module tb_flght_seq;

    localparam int D_DEPTH = 14;
    localparam int D_COEFF = 7;
    localparam int CAL     = 11'h1B0;
    localparam int MRS     = 13'h200;

    typedef int vec3_t [3];

    logic clk = 1'b0;
    logic rst_n;

    flght_seq_if bus();

    flght_seq #(
        .D_DEPTH      (D_DEPTH),
        .D_COEFF      (D_COEFF),
        .CAL_SPEED    (11'h1B0),
        .MIN_RUN_SPEED(13'h200)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference state: error history per axis (oldest first), speeds, drop count
    int hist [3][$];
    int m_spd [4];
    int m_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 3; a++) hist[a].delete();
        for (int k = 0; k < 4; k++) m_spd[k] = 0;
        m_ovr = 0;
    endtask

    // One reading through the control law: P/D per axis, then mix
    task automatic model_accept(input vec3_t act, input vec3_t des, input int thr, input bit cal);
        int term [3];
        int e, p, old, dd, s;
        for (int a = 0; a < 3; a++) begin
            e   = clampi(act[a] - des[a], -512, 511);
            p   = (e >>> 1) + (e >>> 3);
            old = 0;
            if (hist[a].size() == D_DEPTH) old = hist[a].pop_front();
            dd  = e - old;
            if (dd > 511) dd -= 1024;
            else if (dd < -512) dd += 1024;
            hist[a].push_back(e);
            term[a] = p + clampi(dd, -32, 31) * D_COEFF;
        end
        s = MRS + thr;
        if (cal) begin
            for (int k = 0; k < 4; k++) m_spd[k] = CAL;
        end else begin
            m_spd[0] = clampi(s - term[0] - term[2], 0, 2047);
            m_spd[1] = clampi(s + term[0] - term[2], 0, 2047);
            m_spd[2] = clampi(s - term[1] + term[2], 0, 2047);
            m_spd[3] = clampi(s + term[1] + term[2], 0, 2047);
        end
    endtask

    task automatic chk_speeds(input string tag);
        chk({tag, ".frnt"}, bus.frnt_spd, m_spd[0]);
        chk({tag, ".bck"},  bus.bck_spd,  m_spd[1]);
        chk({tag, ".lft"},  bus.lft_spd,  m_spd[2]);
        chk({tag, ".rght"}, bus.rght_spd, m_spd[3]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.vld = 1'b0;
        bus.inertial_cal = 1'b0;
        tick();
        tick();
        model_reset();
        chk("rst.busy", bus.busy, 0);
        chk("rst.spd_vld", bus.spd_vld, 0);
        chk("rst.ovr", bus.ovr_cnt, 0);
        chk_speeds("rst");
        rst_n = 1'b1;
    endtask

    // Accept one reading; busy_vld gives vld during each of the four busy cycles
    task automatic accept(input vec3_t act, input vec3_t des, input int thr,
                          input bit cal, input logic [3:0] busy_vld);
        bus.ptch = 16'(act[0]); bus.roll = 16'(act[1]); bus.yaw = 16'(act[2]);
        bus.d_ptch = 16'(des[0]); bus.d_roll = 16'(des[1]); bus.d_yaw = 16'(des[2]);
        bus.thrst = 9'(thr);
        bus.inertial_cal = cal;
        bus.vld = 1'b1;
        tick();
        // Inputs after capture must not matter
        bus.ptch = 16'($urandom); bus.roll = 16'($urandom); bus.yaw = 16'($urandom);
        bus.d_ptch = 16'($urandom); bus.d_roll = 16'($urandom); bus.d_yaw = 16'($urandom);
        bus.thrst = 9'($urandom);
        for (int i = 0; i < 4; i++) begin
            bus.vld = busy_vld[i];
            if (busy_vld[i] && m_ovr < 255) m_ovr++;
            chk("seq.busy", bus.busy, 1);
            chk("seq.spd_vld_low", bus.spd_vld, 0);
            tick();
        end
        bus.vld = 1'b0;
        model_accept(act, des, thr, cal);
        chk("done.spd_vld", bus.spd_vld, 1);
        chk("done.busy", bus.busy, 0);
        chk("done.ovr", bus.ovr_cnt, m_ovr);
        chk_speeds("done");
    endtask

    initial begin
        vec3_t a, d;
        rst_n = 1'b0;
        bus.vld = 1'b0;
        bus.inertial_cal = 1'b0;
        bus.ptch = '0; bus.roll = '0; bus.yaw = '0;
        bus.d_ptch = '0; bus.d_roll = '0; bus.d_yaw = '0;
        bus.thrst = '0;

        // Single pitch reading
        do_reset();
        accept('{100, 0, 0}, '{0, 0, 0}, 0, 1'b0, 4'h0);
        chk("s1.frnt", bus.frnt_spd, 233);
        chk("s1.bck",  bus.bck_spd,  791);
        chk("s1.lft",  bus.lft_spd,  512);
        chk("s1.rght", bus.rght_spd, 512);
        tick();
        chk("s1.spd_vld_pulse", bus.spd_vld, 0);
        chk("s1.hold", bus.frnt_spd, 233);

        // Derivative history wraps after D_DEPTH readings
        do_reset();
        for (int n = 1; n <= D_DEPTH; n++) begin
            accept('{100, 0, 0}, '{0, 0, 0}, 0, 1'b0, 4'h0);
            tick();
        end
        chk("wrap.before", bus.frnt_spd, 233);
        accept('{100, 0, 0}, '{0, 0, 0}, 0, 1'b0, 4'h0);
        chk("wrap.frnt", bus.frnt_spd, 450);
        chk("wrap.bck",  bus.bck_spd,  574);

        // High saturation
        do_reset();
        accept('{0, 1000, 1000}, '{0, 0, 0}, 511, 1'b0, 4'h0);
        chk("sathi.rght", bus.rght_spd, 2047);
        chk("sathi.lft",  bus.lft_spd,  1023);
        chk("sathi.frnt", bus.frnt_spd, 488);
        chk("sathi.bck",  bus.bck_spd,  488);

        // Low saturation and negative error clamp
        do_reset();
        accept('{0, 1000, -1000}, '{0, 0, 0}, 0, 1'b0, 4'h0);
        chk("satlo.lft", bus.lft_spd, 0);

        // vld held high: accepts every 5 cycles, 4 drops each
        do_reset();
        for (int n = 0; n < 4; n++) accept('{100, 0, 0}, '{0, 0, 0}, 0, 1'b0, 4'hF);
        chk("held.ovr16", bus.ovr_cnt, 16);
        for (int n = 0; n < 66; n++)
            accept('{int'($urandom_range(0, 400)) - 200, 0, 0}, '{0, 0, 0}, 100, 1'b0, 4'hF);
        chk("held.ovr_sat", bus.ovr_cnt, 255);

        // Calibration override
        do_reset();
        bus.inertial_cal = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) m_spd[k] = CAL;
        chk_speeds("cal.idle");
        accept('{100, 0, 0}, '{0, 0, 0}, 0, 1'b1, 4'h0);
        bus.inertial_cal = 1'b0;
        tick();
        tick();
        chk("cal.hold", bus.frnt_spd, CAL);
        accept('{100, 0, 0}, '{0, 0, 0}, 0, 1'b0, 4'h0);
        chk("cal.after", bus.frnt_spd, 233);

        // Reset during ROLL aborts the sequence
        do_reset();
        bus.ptch = 16'd100;
        bus.vld = 1'b1;
        tick();
        bus.vld = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        model_reset();
        chk("midrst.busy", bus.busy, 0);
        chk("midrst.spd_vld", bus.spd_vld, 0);
        chk_speeds("midrst");
        rst_n = 1'b1;
        tick();
        chk("midrst.no_pulse", bus.spd_vld, 0);
        accept('{100, 0, 0}, '{0, 0, 0}, 0, 1'b0, 4'h0);
        chk("midrst.frnt", bus.frnt_spd, 233);
        chk("midrst.bck",  bus.bck_spd,  791);

        // Randomized readings with drop noise and occasional calibration
        do_reset();
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 1) == 0) begin
                    a[k] = int'($urandom_range(0, 65535)) - 32768;
                    d[k] = int'($urandom_range(0, 65535)) - 32768;
                end else begin
                    a[k] = int'($urandom_range(0, 1400)) - 700;
                    d[k] = int'($urandom_range(0, 200)) - 100;
                end
            end
            accept(a, d, int'($urandom_range(0, 511)), ($urandom_range(0, 7) == 0),
                   4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 0) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
